rob_tag_alloc: RTL and testbench

//   Allocates ROB tags to the dispatcher in program order and retires them in order on ROB commit.

---
 rtl/rob_tag_alloc_if.sv | 27 ++
 rtl/rob_tag_alloc.sv | 97 +++++++++
 tb/tb_rob_tag_alloc.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rob_tag_alloc_if.sv
// Dispatcher/ROB handshake bundle for the ROB tag allocator.
// The master side requests tags and commits; the slave side is the allocator.
interface rob_tag_alloc_if #(
   parameter int ROB_WIDTH = 4
);
   logic                 alloc_req_dp;
   logic                 alloc_gnt_dp;
   logic [ROB_WIDTH-1:0] alloc_tag_dp;
   logic                 commit_rob;
   logic [ROB_WIDTH-1:0] head_tag_rob;

   modport master (
      output alloc_req_dp,
      output commit_rob,
      input  alloc_gnt_dp,
      input  alloc_tag_dp,
      input  head_tag_rob
   );

   modport slave (
      input  alloc_req_dp,
      input  commit_rob,
      output alloc_gnt_dp,
      output alloc_tag_dp,
      output head_tag_rob
   );
endinterface

// File: rtl/rob_tag_alloc.sv
// In-order ROB tag allocator: circular head/tail over 2**ROB_WIDTH tags,
// with a timed FLUSH state that holds allocation off while the RF busy bits clear.
module rob_tag_alloc #(
   parameter int ROB_WIDTH    = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 flush_in,
   rob_tag_alloc_if.slave       bus,
   output logic                 rf_clear_out,
   output logic [ROB_WIDTH:0]   count_out,
   output logic                 full_out,
   output logic                 empty_out,
   output logic                 err_out
);

   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FW-1:0]      FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
   localparam logic [ROB_WIDTH:0] DEPTH      = (ROB_WIDTH + 1)'(1) << ROB_WIDTH;

   typedef enum logic {RUN, FLUSH} state_t;

   state_t               state, state_n;
   logic [ROB_WIDTH-1:0] head, head_n, tail, tail_n;
   logic [ROB_WIDTH:0]   count, count_n;
   logic [FW-1:0]        fcnt, fcnt_n;
   logic                 err, err_n;
   logic                 gnt, full, empty, commit_ok;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= RUN;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         fcnt  <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         head  <= head_n;
         tail  <= tail_n;
         count <= count_n;
         fcnt  <= fcnt_n;
         err   <= err_n;
      end
   end

   // Everything holds unless rdy_in; flush outranks both grant and commit.
   always_comb begin
      state_n   = state;
      head_n    = head;
      tail_n    = tail;
      count_n   = count;
      fcnt_n    = fcnt;
      err_n     = err;
      commit_ok = 1'b0;
      if (rdy_in) begin
         if (flush_in) begin
            state_n = FLUSH;
            fcnt_n  = FLUSH_LAST;
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
         end else if (state == FLUSH) begin
            if (fcnt == '0) state_n = RUN;
            else            fcnt_n  = fcnt - 1'b1;
         end else begin
            commit_ok = bus.commit_rob & ~empty;
            if (bus.commit_rob && empty) err_n = 1'b1;
            if (gnt)       tail_n = tail + 1'b1;
            if (commit_ok) head_n = head + 1'b1;
            case ({gnt, commit_ok})
               2'b10:   count_n = count + 1'b1;
               2'b01:   count_n = count - 1'b1;
               default: count_n = count;
            endcase
         end
      end
   end

   always_comb begin
      full             = (count == DEPTH);
      empty            = (count == '0);
      gnt              = (state == RUN) & bus.alloc_req_dp & rdy_in & ~full & ~flush_in;
      bus.alloc_gnt_dp = gnt;
      bus.alloc_tag_dp = tail;
      bus.head_tag_rob = head;
      rf_clear_out     = (state == FLUSH);
      count_out        = count;
      full_out         = full;
      empty_out        = empty;
      err_out          = err;
   end

endmodule

// File: tb/tb_rob_tag_alloc.sv
// Directed-vector bench for rob_tag_alloc: table of per-cycle inputs and
// pre-edge expected outputs, plus a hand sequence for async reset mid-FLUSH.
module tb_rob_tag_alloc;

   logic clk_in = 1'b0;
   logic rst_n_in, rdy_in, flush_in;
   logic rf_clear_out, full_out, empty_out, err_out;
   logic [4:0] count_out;

   rob_tag_alloc_if #(.ROB_WIDTH(4)) bus ();

   rob_tag_alloc #(.ROB_WIDTH(4), .FLUSH_CYCLES(2)) dut (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .rdy_in       (rdy_in),
      .flush_in     (flush_in),
      .bus          (bus.slave),
      .rf_clear_out (rf_clear_out),
      .count_out    (count_out),
      .full_out     (full_out),
      .empty_out    (empty_out),
      .err_out      (err_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic       rdy, req, com, fl;
      logic       gnt;
      logic [3:0] tag, head;
      logic [4:0] cnt;
      logic       err, rfc;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic add(input logic rdy, req, com, fl, gnt,
                      input int tag, head, cnt,
                      input logic err, rfc);
      vec_t v;
      v.rdy = rdy; v.req = req; v.com = com; v.fl = fl; v.gnt = gnt;
      v.tag = 4'(tag); v.head = 4'(head); v.cnt = 5'(cnt);
      v.err = err; v.rfc = rfc;
      tbl.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      rdy_in          = v.rdy;
      bus.alloc_req_dp = v.req;
      bus.commit_rob   = v.com;
      flush_in        = v.fl;
   endtask

   task automatic check(input string nm, input vec_t e);
      logic ef, ee;
      ef = (e.cnt == 5'd16);
      ee = (e.cnt == 5'd0);
      n_vec++;
      if (bus.alloc_gnt_dp !== e.gnt || bus.alloc_tag_dp !== e.tag ||
          bus.head_tag_rob !== e.head || count_out !== e.cnt ||
          full_out !== ef || empty_out !== ee || err_out !== e.err ||
          rf_clear_out !== e.rfc) begin
         n_bad++;
         $display("FAIL %s: got gnt=%b tag=%0d head=%0d cnt=%0d full=%b empty=%b err=%b rfc=%b, want gnt=%b tag=%0d head=%0d cnt=%0d full=%b empty=%b err=%b rfc=%b",
                  nm, bus.alloc_gnt_dp, bus.alloc_tag_dp, bus.head_tag_rob, count_out,
                  full_out, empty_out, err_out, rf_clear_out,
                  e.gnt, e.tag, e.head, e.cnt, ef, ee, e.err, e.rfc);
      end
   endtask

   initial begin
      vec_t z;
      // Expected values are the outputs seen before the edge that consumes the inputs.
      for (int i = 0; i < 16; i++) add(1, 1, 0, 0, 1, i, 0, i, 0, 0);
      add(1, 1, 0, 0, 0, 0, 0, 16, 0, 0);                            // 17th request refused
      add(1, 1, 1, 0, 0, 0, 0, 16, 0, 0);                            // full: commit only
      add(1, 1, 0, 0, 1, 0, 1, 15, 0, 0);                            // wrapped tag 0
      for (int i = 0; i < 11; i++) add(1, 0, 1, 0, 0, 1, 1 + i, 16 - i, 0, 0);
      for (int i = 0; i < 4; i++)  add(1, 1, 1, 0, 1, 1 + i, 12 + i, 5, 0, 0);
      add(1, 1, 0, 0, 1, 5, 0, 5, 0, 0);
      add(1, 1, 0, 0, 1, 6, 0, 6, 0, 0);
      add(1, 1, 0, 1, 0, 7, 0, 7, 0, 0);                             // flush beats alloc
      add(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);                             // FLUSH: commit ignored
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);                             // back in RUN, tag 0
      add(1, 0, 1, 0, 0, 1, 0, 1, 0, 0);
      add(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);                             // commit while empty
      add(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
      add(1, 1, 0, 0, 1, 1, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 2, 1, 1, 1, 0);  // frozen
      add(1, 0, 0, 0, 0, 2, 1, 1, 1, 0);
      add(1, 0, 0, 1, 0, 2, 1, 1, 1, 0);
      add(1, 0, 0, 1, 0, 0, 0, 0, 1, 1);                             // flush restarts FLUSH
      add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);

      z = '{rdy: 1'b1, req: 1'b0, com: 1'b0, fl: 1'b0, gnt: 1'b0,
            tag: 4'd0, head: 4'd0, cnt: 5'd0, err: 1'b0, rfc: 1'b0};

      rst_n_in = 1'b0;
      drive(z);
      #7 check("reset", z);
      @(negedge clk_in) rst_n_in = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk_in);
         drive(tbl[i]);
         #2 check($sformatf("vec%0d", i), tbl[i]);
      end

      // Async reset in the middle of FLUSH, sampled before any clock edge.
      @(negedge clk_in);
      flush_in = 1'b1;
      #2 check("pre_flush", '{1, 0, 0, 1, 0, 0, 0, 0, 1, 0});
      @(negedge clk_in);
      flush_in = 1'b0;
      #2 check("in_flush", '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1});
      #1 rst_n_in = 1'b0;
      #1 check("async_rst", z);
      @(negedge clk_in) rst_n_in = 1'b1;
      bus.alloc_req_dp = 1'b1;
      #2 check("post_rst_gnt", '{1, 1, 0, 0, 1, 0, 0, 0, 0, 0});
      @(negedge clk_in) drive(z);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule
